// File: rtl/seq_multiplier_pkg.sv
// Shared definitions for the multi-cycle ALU units: state encoding used by seq_multiplier.
package seq_multiplier_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  typedef enum logic [1:0] {
    StIdle = IDLE,
    StCalc = CALC,
    StDone = DONE
  } state_e;

endpackage

// File: rtl/nbit_adder.sv
// Width-bit ripple adder with carry in and carry out.
module nbit_adder #(
  parameter int unsigned Width = 8
) (
  input  logic [Width-1:0] A,
  input  logic [Width-1:0] B,
  input  logic             Cin,
  output logic [Width-1:0] Sum,
  output logic             Cout
);

  always_comb begin
    {Cout, Sum} = {1'b0, A} + {1'b0, B} + {{Width{1'b0}}, Cin};
  end

endmodule

// File: rtl/seq_multiplier.sv
// Unsigned shift-and-add multiplier: one multiplier bit per clock, 2*Width-bit registered product.
module seq_multiplier
  import seq_multiplier_pkg::*;
#(
  parameter int unsigned Width = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [Width-1:0]   A,
  input  logic [Width-1:0]   B,
  output logic [2*Width-1:0] Product,
  output logic               busy,
  output logic               done
);

  localparam int unsigned CntW = (Width > 1) ? $clog2(Width) : 1;

  state_e               state_q, state_d;
  logic [Width-1:0]     mcand_q, hi_q, lo_q;
  logic [CntW-1:0]      count_q;
  logic [2*Width-1:0]   product_q;

  logic [Width-1:0]     add_sum;
  logic                 add_cout;
  logic [Width:0]       partial;
  logic [2*Width-1:0]   shifted;
  logic                 last;
  logic                 accept;

  nbit_adder #(
    .Width (Width)
  ) u_adder (
    .A    (hi_q),
    .B    (mcand_q),
    .Cin  (1'b0),
    .Sum  (add_sum),
    .Cout (add_cout)
  );

  // Carry is kept as the top bit of the shifted value, so the product is exact.
  always_comb begin
    partial = lo_q[0] ? {add_cout, add_sum} : {1'b0, hi_q};
    shifted = {partial, lo_q[Width-1:1]};
    last    = (count_q == CntW'(Width - 1));
    accept  = start && ((state_q == StIdle) || (state_q == StDone));
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StCalc;
      StCalc:  if (last) state_d = StDone;
      StDone:  state_d = start ? StCalc : StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      mcand_q   <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      count_q   <= '0;
      product_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        mcand_q <= A;
        lo_q    <= B;
        hi_q    <= '0;
        count_q <= '0;
      end else if (state_q == StCalc) begin
        {hi_q, lo_q} <= shifted;
        if (last) begin
          product_q <= shifted;
        end else begin
          count_q <= count_q + 1'b1;
        end
      end
    end
  end

  assign Product = product_q;
  assign busy    = (state_q == StCalc);
  assign done    = (state_q == StDone);

endmodule

// File: tb/tb_seq_multiplier.sv
// Scoreboard bench for seq_multiplier at Width=8 and an exhaustive Width=4 sweep.
module tb_seq_multiplier;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [15:0] product8;
  logic        busy8, done8;
  logic        start4 = 1'b0;
  logic [3:0]  a4 = '0, b4 = '0;
  logic [7:0]  product4;
  logic        busy4, done4;

  int total = 0;
  int bad = 0;

  logic [15:0] exp_q8[$];
  logic [7:0]  exp_q4[$];

  always #5 clk = ~clk;

  seq_multiplier #(.Width(8)) dut8 (
    .clk     (clk),
    .rst     (rst),
    .start   (start8),
    .A       (a8),
    .B       (b8),
    .Product (product8),
    .busy    (busy8),
    .done    (done8)
  );

  seq_multiplier #(.Width(4)) dut4 (
    .clk     (clk),
    .rst     (rst),
    .start   (start4),
    .A       (a4),
    .B       (b4),
    .Product (product4),
    .busy    (busy4),
    .done    (done4)
  );

  // Waits for done8; inputs are updated on the first negedge after the start edge.
  task automatic wait_done8(input logic hold, input logic [7:0] na, input logic [7:0] nb,
                            output int lat, output logic busy_ok, output logic stable);
    logic [15:0] p0;
    p0 = product8;
    lat = 0;
    busy_ok = 1'b1;
    stable = 1'b1;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        start8 = hold;
        a8 = na;
        b8 = nb;
      end
      if (!done8) begin
        if (busy8 !== 1'b1) busy_ok = 1'b0;
        if (product8 !== p0) stable = 1'b0;
      end
    end while (!done8 && lat < 30);
  endtask

  task automatic wait_done4(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) start4 = 1'b0;
    end while (!done4 && lat < 30);
  endtask

  task automatic launch8(input logic [7:0] a, input logic [7:0] b);
    start8 = 1'b1;
    a8 = a;
    b8 = b;
    exp_q8.push_back(16'(a) * 16'(b));
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++; if (product8 !== 16'h0) begin bad++; $display("FAIL reset_product got=%h exp=0", product8); end
    total++; if (busy8 !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy8); end
    total++; if (done8 !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done8); end
  endtask

  task automatic test_basic;
    int lat;
    logic busy_ok, stable;
    logic [15:0] exp;
    launch8(8'd255, 8'd255);
    wait_done8(1'b0, 8'hxx, 8'hxx, lat, busy_ok, stable);
    exp = (exp_q8.size() != 0) ? exp_q8.pop_front() : 'x;
    total++; if (lat != 9) begin bad++; $display("FAIL basic_latency got=%0d exp=9", lat); end
    total++; if (!busy_ok) begin bad++; $display("FAIL basic_busy got=0 exp=1"); end
    total++; if (product8 !== exp) begin bad++; $display("FAIL basic_product got=%h exp=%h", product8, exp); end
    total++; if (exp !== 16'hFE01) begin bad++; $display("FAIL basic_model got=%h exp=fe01", exp); end
    @(negedge clk);
    total++; if (done8 !== 1'b0) begin bad++; $display("FAIL basic_done_fall got=%b exp=0", done8); end
  endtask

  task automatic test_identity;
    logic [7:0] as [3] = '{8'd0, 8'd1, 8'd200};
    logic [7:0] bs [3] = '{8'd173, 8'd173, 8'd1};
    int lat;
    logic busy_ok, stable;
    logic [15:0] exp;
    for (int i = 0; i < 3; i++) begin
      launch8(as[i], bs[i]);
      wait_done8(1'b0, 8'h5a, 8'ha5, lat, busy_ok, stable);
      exp = (exp_q8.size() != 0) ? exp_q8.pop_front() : 'x;
      total++; if (lat != 9) begin bad++; $display("FAIL ident_latency[%0d] got=%0d exp=9", i, lat); end
      total++; if (product8 !== exp) begin bad++; $display("FAIL ident_product[%0d] got=%h exp=%h", i, product8, exp); end
      @(negedge clk);
      total++; if (done8 !== 1'b0) begin bad++; $display("FAIL ident_done_fall[%0d] got=%b exp=0", i, done8); end
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    logic busy_ok, stable;
    logic [15:0] exp;
    launch8(8'd12, 8'd13);
    wait_done8(1'b0, 8'h00, 8'h00, lat, busy_ok, stable);
    exp = (exp_q8.size() != 0) ? exp_q8.pop_front() : 'x;
    total++; if (product8 !== exp) begin bad++; $display("FAIL b2b_first got=%h exp=%h", product8, exp); end
    launch8(8'd100, 8'd3);
    wait_done8(1'b0, 8'hff, 8'hff, lat, busy_ok, stable);
    exp = (exp_q8.size() != 0) ? exp_q8.pop_front() : 'x;
    total++; if (lat != 9) begin bad++; $display("FAIL b2b_latency got=%0d exp=9", lat); end
    total++; if (!busy_ok) begin bad++; $display("FAIL b2b_no_idle got=0 exp=1"); end
    total++; if (!stable) begin bad++; $display("FAIL b2b_hold got=changed exp=156"); end
    total++; if (product8 !== exp) begin bad++; $display("FAIL b2b_second got=%h exp=%h", product8, exp); end
    @(negedge clk);
  endtask

  task automatic test_start_in_calc;
    int lat;
    logic busy_ok, stable;
    logic [15:0] exp;
    launch8(8'd7, 8'd9);
    wait_done8(1'b1, 8'd255, 8'd255, lat, busy_ok, stable);
    exp = (exp_q8.size() != 0) ? exp_q8.pop_front() : 'x;
    total++; if (lat != 9) begin bad++; $display("FAIL calc_start_latency got=%0d exp=9", lat); end
    total++; if (product8 !== exp) begin bad++; $display("FAIL calc_start_product got=%h exp=%h", product8, exp); end
    // start is still high here, so the held request is taken at this DONE edge.
    exp_q8.push_back(16'd65025);
    wait_done8(1'b0, 8'h00, 8'h00, lat, busy_ok, stable);
    exp = (exp_q8.size() != 0) ? exp_q8.pop_front() : 'x;
    total++; if (lat != 9) begin bad++; $display("FAIL calc_second_latency got=%0d exp=9", lat); end
    total++; if (!busy_ok) begin bad++; $display("FAIL calc_second_busy got=0 exp=1"); end
    total++; if (product8 !== exp) begin bad++; $display("FAIL calc_second_product got=%h exp=%h", product8, exp); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_op;
    int lat;
    logic busy_ok, stable;
    logic [15:0] exp;
    logic done_seen;
    start8 = 1'b1;
    a8 = 8'd50;
    b8 = 8'd50;
    @(negedge clk);
    start8 = 1'b0;
    repeat (2) @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++; if (busy8 !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b exp=0", busy8); end
    total++; if (product8 !== 16'h0) begin bad++; $display("FAIL midrst_product got=%h exp=0", product8); end
    done_seen = done8;
    repeat (15) begin
      @(negedge clk);
      if (done8 !== 1'b0) done_seen = 1'b1;
    end
    total++; if (done_seen !== 1'b0) begin bad++; $display("FAIL midrst_no_done got=%b exp=0", done_seen); end
    launch8(8'd3, 8'd4);
    wait_done8(1'b0, 8'h00, 8'h00, lat, busy_ok, stable);
    exp = (exp_q8.size() != 0) ? exp_q8.pop_front() : 'x;
    total++; if (lat != 9) begin bad++; $display("FAIL midrst_latency got=%0d exp=9", lat); end
    total++; if (product8 !== exp) begin bad++; $display("FAIL midrst_product2 got=%h exp=%h", product8, exp); end
    @(negedge clk);
  endtask

  task automatic test_exhaustive4;
    int lat;
    logic [7:0] exp;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        start4 = 1'b1;
        a4 = 4'(a);
        b4 = 4'(b);
        exp_q4.push_back(8'(a * b));
        wait_done4(lat);
        exp = (exp_q4.size() != 0) ? exp_q4.pop_front() : 'x;
        total++; if (lat != 5) begin bad++; $display("FAIL w4_latency a=%0d b=%0d got=%0d exp=5", a, b, lat); end
        total++; if (product4 !== exp) begin bad++; $display("FAIL w4_product a=%0d b=%0d got=%h exp=%h", a, b, product4, exp); end
        @(negedge clk);
        total++; if (done4 !== 1'b0) begin bad++; $display("FAIL w4_done_fall a=%0d b=%0d got=%b exp=0", a, b, done4); end
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset;
    test_basic;
    test_identity;
    test_back_to_back;
    test_start_in_calc;
    test_reset_mid_op;
    test_exhaustive4;
    total++;
    if (exp_q8.size() != 0 || exp_q4.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain got=%0d/%0d exp=0/0", exp_q8.size(), exp_q4.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
